// File: rtl/rv_pkg.sv
// Shared RV32I-subset definitions: opcodes, funct3 codes, phase and ALU-op enums.
package rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        EXEC,
        WB
    } phase_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_t;

    // alt selects SUB over ADD and SRA over SRL (instruction bit 30)
    function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational integer ALU; shifts use the low 5 bits of b.
module rv_alu
    import rv_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         alu_op,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = '0;
        case (alu_op)
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_SLL:    y = a << b[4:0];
            ALU_SLT:    y = XLEN'($signed(a) < $signed(b));
            ALU_SLTU:   y = XLEN'(a < b);
            ALU_XOR:    y = a ^ b;
            ALU_SRL:    y = a >> b[4:0];
            ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:     y = a | b;
            ALU_AND:    y = a & b;
            ALU_PASS_B: y = b;
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/main_cpu.sv
// Multi-cycle RV32I-subset core: one instruction per FETCH/DECODE/EXEC/WB slot,
// external instruction word, internal PC and 32x32 register file.
module main_cpu
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] in_bus,
    output logic [XLEN-1:0] out_bus
);

    phase_t phase;
    phase_t phase_next;

    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] npc;
    logic            wr_pend;
    logic            ld_pend;
    logic            st_pend;
    logic [XLEN-1:0] regs [NREGS];

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   imm_dec;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    alu_op_t           alu_op;
    logic [XLEN-1:0]   alu_y;
    logic              br_taken;
    logic [XLEN-1:0]   exec_val;
    logic [XLEN-1:0]   exec_npc;
    logic              exec_wr;
    logic              exec_ld;
    logic              exec_st;
    logic [XLEN-1:0]   wb_data;

    assign opcode   = ir[6:0];
    assign funct3   = ir[14:12];
    assign rd       = ir[11:7];
    assign pc_plus4 = pc + XLEN'(4);
    assign wb_data  = ld_pend ? in_bus : result;

    // Phase state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= FETCH;
        end else begin
            phase <= phase_next;
        end
    end

    always_comb begin
        phase_next = phase;
        case (phase)
            FETCH:   phase_next = DECODE;
            DECODE:  phase_next = EXEC;
            EXEC:    phase_next = WB;
            WB:      phase_next = FETCH;
            default: phase_next = FETCH;
        endcase
    end

    // Immediate generation by instruction format
    always_comb begin
        imm_dec = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC:
                imm_dec = {ir[31:12], 12'b0};
            OPC_JAL:
                imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            OPC_BRANCH:
                imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OPC_STORE:
                imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OPC_JALR, OPC_LOAD, OPC_OP_IMM:
                imm_dec = {{20{ir[31]}}, ir[31:20]};
            default:
                imm_dec = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken = (rs1_val == rs2_val);
            F3_BNE:  br_taken = (rs1_val != rs2_val);
            F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: br_taken = (rs1_val < rs2_val);
            F3_BGEU: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    rv_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .alu_op (alu_op),
        .y      (alu_y)
    );

    // Execute: operand select, writeback value and next PC
    always_comb begin
        alu_a    = rs1_val;
        alu_b    = imm;
        alu_op   = ALU_ADD;
        exec_val = alu_y;
        exec_npc = pc_plus4;
        exec_wr  = 1'b0;
        exec_ld  = 1'b0;
        exec_st  = 1'b0;
        case (opcode)
            OPC_LUI: begin
                alu_op  = ALU_PASS_B;
                exec_wr = 1'b1;
            end
            OPC_AUIPC: begin
                alu_a   = pc;
                exec_wr = 1'b1;
            end
            OPC_JAL: begin
                alu_a    = pc;
                exec_val = pc_plus4;
                exec_npc = alu_y;
                exec_wr  = 1'b1;
            end
            OPC_JALR: begin
                exec_val = pc_plus4;
                exec_npc = {alu_y[XLEN-1:1], 1'b0};
                exec_wr  = 1'b1;
            end
            OPC_BRANCH: begin
                alu_a = pc;
                if (br_taken) begin
                    exec_npc = alu_y;
                end
            end
            OPC_OP_IMM: begin
                alu_op  = alu_op_from_f3(funct3, ir[30] && (funct3 == F3_SR));
                exec_wr = 1'b1;
            end
            OPC_OP: begin
                alu_b   = rs2_val;
                alu_op  = alu_op_from_f3(funct3, ir[30]);
                exec_wr = 1'b1;
            end
            OPC_LOAD: begin
                exec_wr = 1'b1;
                exec_ld = 1'b1;
            end
            OPC_STORE: begin
                exec_st = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers, each loaded in its own phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir      <= '0;
            pc      <= RESET_PC;
            rs1_val <= '0;
            rs2_val <= '0;
            imm     <= '0;
            result  <= '0;
            npc     <= '0;
            wr_pend <= 1'b0;
            ld_pend <= 1'b0;
            st_pend <= 1'b0;
            out_bus <= '0;
        end else begin
            case (phase)
                FETCH: begin
                    ir <= inst;
                end
                DECODE: begin
                    rs1_val <= regs[ir[19:15]];
                    rs2_val <= regs[ir[24:20]];
                    imm     <= imm_dec;
                end
                EXEC: begin
                    result  <= exec_val;
                    npc     <= exec_npc;
                    wr_pend <= exec_wr;
                    ld_pend <= exec_ld;
                    st_pend <= exec_st;
                end
                WB: begin
                    pc <= npc;
                    if (wr_pend) begin
                        out_bus <= wb_data;
                    end else if (st_pend) begin
                        out_bus <= rs2_val;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register file; x0 is never written so it always reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (phase == WB && wr_pend && rd != '0) begin
            regs[rd] <= wb_data;
        end
    end

endmodule

// File: tb/tb_main_cpu.sv
// Self-checking bench for main_cpu: directed sequence, mid-instruction reset and
// randomized instructions against an instruction-level reference model.
module tb_main_cpu;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = '0;
    logic [31:0] in_bus = '0;
    logic [31:0] out_bus;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] m_out;

    main_cpu dut (
        .clk     (clk),
        .rst     (rst),
        .inst    (inst),
        .in_bus  (in_bus),
        .out_bus (out_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_u(input logic [31:0] v, input logic [4:0] rd, input logic [6:0] opc);
        return {v[31:12], rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] v, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {v[11:0], rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] v, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {v[11:5], rs2, rs1, f3, v[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] v, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] v, input logic [4:0] rd);
        return {v[20], v[10:1], v[11], v[19:12], rd, OPC_JAL};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc  = 32'h0;
        m_out = 32'h0;
    endtask

    // Architectural effect of one instruction, straight from the ISA rules
    task automatic model_step(input logic [31:0] ins, input logic [31:0] din);
        logic [31:0] a, b, iv, uv, jv, bv, val, nxt;
        logic        wr, tk;
        a   = m_regs[ins[19:15]];
        b   = m_regs[ins[24:20]];
        iv  = {{20{ins[31]}}, ins[31:20]};
        uv  = {ins[31:12], 12'h000};
        jv  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        bv  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        val = 32'h0;
        nxt = m_pc + 32'd4;
        wr  = 1'b0;
        tk  = 1'b0;
        case (ins[6:0])
            OPC_LUI:   begin val = uv; wr = 1'b1; end
            OPC_AUIPC: begin val = m_pc + uv; wr = 1'b1; end
            OPC_JAL:   begin val = m_pc + 32'd4; nxt = m_pc + jv; wr = 1'b1; end
            OPC_JALR:  begin val = m_pc + 32'd4; nxt = (a + iv) & ~32'd1; wr = 1'b1; end
            OPC_BRANCH: begin
                case (ins[14:12])
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = !($signed(a) < $signed(b));
                    3'd6: tk = (a < b);
                    3'd7: tk = !(a < b);
                    default: tk = 1'b0;
                endcase
                if (tk) nxt = m_pc + bv;
            end
            OPC_OP_IMM, OPC_OP: begin
                logic [31:0] o;
                o  = (ins[6:0] == OPC_OP) ? b : iv;
                wr = 1'b1;
                case (ins[14:12])
                    3'd0: val = (ins[6:0] == OPC_OP && ins[30]) ? a - o : a + o;
                    3'd1: val = a << o[4:0];
                    3'd2: val = ($signed(a) < $signed(o)) ? 32'd1 : 32'd0;
                    3'd3: val = (a < o) ? 32'd1 : 32'd0;
                    3'd4: val = a ^ o;
                    3'd5: val = ins[30] ? $unsigned($signed(a) >>> o[4:0]) : a >> o[4:0];
                    3'd6: val = a | o;
                    default: val = a & o;
                endcase
            end
            OPC_LOAD:  begin val = din; wr = 1'b1; end
            OPC_STORE: m_out = b;
            default: ;
        endcase
        if (wr) begin
            m_out = val;
            if (ins[11:7] != 5'd0) m_regs[ins[11:7]] = val;
        end
        m_pc = nxt;
    endtask

    // Drive one instruction slot from a negedge; returns whether out_bus held
    // through the first three phases and its value after the WB edge
    task automatic run_inst(input logic [31:0] ins, input logic [31:0] din,
                            output bit held, output logic [31:0] obs);
        logic [31:0] prev;
        prev   = out_bus;
        inst   = ins;
        in_bus = din;
        held   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (out_bus !== prev) held = 1'b0;
        end
        @(negedge clk);
        obs = out_bus;
        model_step(ins, din);
    endtask

    task automatic test_reset();
        bit          held;
        logic [31:0] obs;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        tests_run++;
        if (out_bus !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_out_bus got %h expected %h", out_bus, 32'h0);
        end
        rst = 1'b0;
        run_inst(32'h0, 32'h0, held, obs);
        tests_run++;
        if (obs !== 32'h0 || !held) begin
            tests_failed++;
            $display("FAIL nop_after_reset got %h held=%0d expected %h held=1", obs, held, 32'h0);
        end
    endtask

    task automatic test_directed();
        logic [31:0] prog [16];
        logic [31:0] din  [16];
        logic [31:0] expv [16];
        bit          held;
        logic [31:0] obs;
        prog[0]  = enc_u(32'h1234A000, 5'd1, OPC_LUI);                 expv[0]  = 32'h1234A000;
        prog[1]  = enc_j(32'd8, 5'd1);                                 expv[1]  = 32'd12;
        prog[2]  = enc_j(32'hFFFF_FFFC, 5'd1);                         expv[2]  = 32'd20;
        prog[3]  = enc_j(32'd8, 5'd1);                                 expv[3]  = 32'd16;
        prog[4]  = enc_i(32'd8, 5'd1, 3'b000, 5'd2, OPC_JALR);         expv[4]  = 32'd24;
        prog[5]  = enc_u(32'h22222000, 5'd1, OPC_AUIPC);               expv[5]  = 32'h22222018;
        prog[6]  = enc_i(32'hFFFF_FFFF, 5'd0, 3'b000, 5'd3, OPC_OP_IMM); expv[6] = 32'hFFFFFFFF;
        prog[7]  = enc_i(32'd0, 5'd0, 3'b010, 5'd4, OPC_LOAD);         expv[7]  = 32'd58;
        prog[8]  = enc_b(32'd16, 5'd0, 5'd0, F3_BEQ);                  expv[8]  = 32'd58;
        prog[9]  = enc_u(32'h0, 5'd5, OPC_AUIPC);                      expv[9]  = 32'd52;
        prog[10] = enc_i(32'd5, 5'd0, 3'b000, 5'd0, OPC_OP_IMM);       expv[10] = 32'd5;
        prog[11] = enc_r(7'b0, 5'd0, 5'd0, 3'b000, 5'd6);              expv[11] = 32'd0;
        prog[12] = enc_s(32'd4, 5'd3, 5'd0, 3'b010);                   expv[12] = 32'hFFFFFFFF;
        prog[13] = enc_r(7'b0100000, 5'd3, 5'd0, 3'b000, 5'd7);        expv[13] = 32'd1;
        prog[14] = enc_i(32'h0000_041C, 5'd3, 3'b101, 5'd8, OPC_OP_IMM); expv[14] = 32'hFFFFFFFF;
        prog[15] = enc_i(32'h0000_001C, 5'd3, 3'b101, 5'd8, OPC_OP_IMM); expv[15] = 32'h0000000F;
        for (int i = 0; i < 16; i++) din[i] = (i == 7) ? 32'd58 : 32'hDEAD_0000 + 32'(i);
        for (int i = 0; i < 16; i++) begin
            run_inst(prog[i], din[i], held, obs);
            tests_run++;
            if (obs !== expv[i] || !held) begin
                tests_failed++;
                $display("FAIL directed_%0d inst=%h got %h held=%0d expected %h held=1",
                         i, prog[i], obs, held, expv[i]);
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        bit          held;
        logic [31:0] obs;
        inst = enc_i(32'd123, 5'd0, 3'b000, 5'd8, OPC_OP_IMM);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        tests_run++;
        if (out_bus !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_exec_out got %h expected %h", out_bus, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        run_inst(enc_u(32'h0, 5'd9, OPC_AUIPC), 32'h0, held, obs);
        tests_run++;
        if (obs !== 32'h0 || !held) begin
            tests_failed++;
            $display("FAIL reset_mid_exec_pc got %h expected %h", obs, 32'h0);
        end
        run_inst(enc_r(7'b0, 5'd0, 5'd8, 3'b000, 5'd10), 32'h0, held, obs);
        tests_run++;
        if (obs !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_exec_nowb got %h expected %h", obs, 32'h0);
        end
    endtask

    task automatic test_random();
        bit          held;
        logic [31:0] obs, ins, imm, din, exp_prev;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        alt;
        for (int n = 0; n < 300; n++) begin
            rd  = 5'($urandom);
            rs1 = 5'($urandom);
            rs2 = 5'($urandom);
            imm = $urandom;
            din = $urandom;
            f3  = 3'($urandom);
            alt = 1'($urandom);
            case ($urandom_range(0, 11))
                0: ins = enc_u(imm, rd, OPC_LUI);
                1: ins = enc_u(imm, rd, OPC_AUIPC);
                2: ins = enc_j(imm & 32'h001F_FFFE, rd);
                3: ins = enc_i(imm, rs1, 3'b000, rd, OPC_JALR);
                4: begin
                    case ($urandom_range(0, 5))
                        0: f3 = F3_BEQ;  1: f3 = F3_BNE;  2: f3 = F3_BLT;
                        3: f3 = F3_BGE;  4: f3 = F3_BLTU; default: f3 = F3_BGEU;
                    endcase
                    ins = enc_b(imm & 32'h0000_1FFE, rs2, rs1, f3);
                end
                5, 6: begin
                    if (f3 == 3'b001) imm = {27'b0, imm[4:0]};
                    else if (f3 == 3'b101) imm = {21'b0, alt, 5'b0, imm[4:0]};
                    ins = enc_i(imm, rs1, f3, rd, OPC_OP_IMM);
                end
                7, 8: ins = enc_r((alt && (f3 == 3'b000 || f3 == 3'b101)) ? 7'b0100000 : 7'b0,
                                  rs2, rs1, f3, rd);
                9:  ins = enc_i(imm, rs1, f3, rd, OPC_LOAD);
                10: ins = enc_s(imm, rs2, rs1, f3);
                default: begin
                    case ($urandom_range(0, 2))
                        0: ins = {imm[31:7], 7'b1110011};
                        1: ins = {imm[31:7], 7'b0001111};
                        default: ins = 32'h0;
                    endcase
                end
            endcase
            exp_prev = m_out;
            run_inst(ins, din, held, obs);
            tests_run++;
            if (obs !== m_out || !held) begin
                tests_failed++;
                $display("FAIL random_%0d inst=%h got %h held=%0d expected %h (prev %h)",
                         n, ins, obs, held, m_out, exp_prev);
            end
            // Periodically expose PC and a register through out_bus
            if (n % 10 == 9) begin
                ins = enc_u(32'h0, 5'd0, OPC_AUIPC);
                run_inst(ins, 32'h0, held, obs);
                tests_run++;
                if (obs !== m_out) begin
                    tests_failed++;
                    $display("FAIL random_pc_%0d got %h expected %h", n, obs, m_out);
                end
                ins = enc_i(32'h0, rs1, 3'b000, 5'd0, OPC_OP_IMM);
                run_inst(ins, 32'h0, held, obs);
                tests_run++;
                if (obs !== m_out) begin
                    tests_failed++;
                    $display("FAIL random_reg_x%0d got %h expected %h", rs1, obs, m_out);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_directed();
        test_reset_mid_exec();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/main_cpu.md
Name: main_cpu

Overview:
- Multi-cycle RV32I-subset CPU core; top-level compute block of the design.
- No internal instruction memory. The instruction word is supplied externally on `inst` and held stable for one 4-cycle instruction slot.
- Executes one instruction per 4 clocks and maintains its own PC and 32x32 register file.
- `in_bus` is the load-data input. `out_bus` presents the result of the most recently retired instruction.

Parameters:
- XLEN, 32, datapath/register width
- NREGS, 32, register count (x0 hardwired to zero)
- RESET_PC, 32'h0000_0000, PC value after reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- inst  in  32  current instruction word; must be stable on the FETCH edge
- in_bus  in  32  load data; sampled on the WB edge of a LOAD
- out_bus  out  32  retired result (see Behaviour); registered

Behaviour:
- Reset (async, rst=1):
  - phase=FETCH, PC=RESET_PC, all registers=0, IR=0, out_bus=0.
  - Reset asserted mid-instruction aborts it; no partial writeback.
- Phase FSM, advances every rising edge while rst=0: FETCH -> DECODE -> EXEC -> WB -> FETCH.
  - FETCH: IR <= inst.
  - DECODE: read rs1=IR[19:15], rs2=IR[24:20]; form the sign-extended immediate (I/S/B/U/J formats per RV32I).
  - EXEC: ALU result, branch decision and next-PC computed and registered.
  - WB: rd=IR[11:7] written if the instruction writes and rd!=0; PC updated; out_bus updated.
- Latency: exactly 4 clocks per instruction. The first FETCH edge is the first rising edge after rst deasserts.
- Supported opcodes:
  - LUI: rd=imm_u.
  - AUIPC: rd=PC+imm_u.
  - JAL: rd=PC+4, PC=PC+imm_j.
  - JALR: rd=PC+4, PC=(rs1+imm_i)&~1. Target uses the old rs1 value even when rd==rs1.
  - BRANCH: BEQ/BNE/BLT/BGE/BLTU/BGEU; PC=PC+imm_b if taken, else PC+4; no rd write.
  - OP-IMM: ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - OP: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; SUB/SRA selected by IR[30].
  - LOAD (any funct3): rd=in_bus.
  - STORE: no rd write; out_bus=rs2.
  - Every other opcode, including inst=0: NOP, PC=PC+4, no write, out_bus unchanged.
- out_bus at WB:
  - Equals the value written to rd. This holds even when rd=x0: the computed value is shown, the register stays 0.
  - Equals rs2 for STORE.
  - Held otherwise, including through all non-WB phases.
- Arithmetic: all 32-bit modulo, wrap-around silently; shift amount = low 5 bits. Misaligned jump targets are not trapped; PC bit 0 is cleared only for JALR.
- x0 always reads 0.

Decomposition:
- Shared package `rv_pkg`:
  - opcode constants (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011);
  - funct3 constants;
  - phase enum {FETCH, DECODE, EXEC, WB};
  - ALU-op enum.
- One natural sub-module: `rv_alu`, purely combinational (a, b, alu_op -> y).
- Register file, immediate generation and FSM stay in main_cpu.

Test Plan:
- Release rst after one cycle, inst=0 for 4 cycles -> PC=4, no register changes, out_bus=0.
- LUI x1,0x1234A ({20'h1234A,5'd1,7'b0110111}) at PC=4 -> x1=32'h1234A000, out_bus=32'h1234A000, PC=8.
- JAL x1,+8 (bits[31:12]=20'h00800) at PC=8 -> x1=12, PC=16.
- JAL x1,-4 (bits[31:12]=20'hFFDFF) -> x1=20, PC=12.
- JAL x1,+8 again -> x1=16, PC=20.
- JALR x2,8(x1) ({12'h008,5'd1,3'b000,5'd2,7'b1100111}) -> x2=24, PC=24.
- AUIPC x1,0x22222 at PC=24 -> x1=32'h22222018, PC=28, out_bus=32'h22222018.
- ALU and memory checks:
  - ADDI x3,x0,-1 -> out_bus=32'hFFFFFFFF.
  - LOAD with in_bus=58 -> rd=58.
  - BEQ taken -> PC=PC+imm_b.
  - Write to x0 -> x0 still reads 0.
- Assert rst during EXEC of an instruction -> out_bus=0, PC=0, no writeback; execution restarts at FETCH.
